// File: rtl/bitlet_weight_scheduler_if.sv
// Select interface between the Bitlet weight scheduler (master) and the MAC side (slave).
// Carries the weight-vector load handshake and the per-plane select beat handshake.
interface bitlet_weight_scheduler_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 32,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
);
    // w_in[i] is weight i, a two's-complement value of DATA_WIDTH bits
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    w_in;
    logic                                     w_valid;
    logic                                     w_ready;
    logic                                     out_ready;
    logic                                     out_valid;
    logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] act_sel;
    logic [DATA_WIDTH-1:0]                    act_val;
    logic                                     last;

    modport master (
        input  w_in, w_valid, out_ready,
        output w_ready, out_valid, act_sel, act_val, last
    );

    modport slave (
        output w_in, w_valid, out_ready,
        input  w_ready, out_valid, act_sel, act_val, last
    );
endinterface

// File: rtl/bitlet_weight_scheduler.sv
// Transposes a signed weight vector into bit-plane masks and streams, one beat at a time,
// the lowest remaining set lane of every plane as an activation select for the Bitlet MAC.
module bitlet_weight_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 32,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    bitlet_weight_scheduler_if.master     bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [VEC_LENGTH-1:0] ONE_V = VEC_LENGTH'(1'b1);

    state_t                                   state_r;
    state_t                                   state_nxt_s;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    mask_r;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    mask_nxt_s;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    mask_load_s;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]    mask_clr_s;
    logic [DATA_WIDTH-1:0]                    single_s;
    logic [DATA_WIDTH-1:0]                    act_val_s;
    logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] act_sel_s;
    logic                                     out_valid_s;
    logic                                     last_s;
    logic                                     beat_done_s;
    logic                                     w_ready_s;
    logic                                     accept_s;

    // Per-plane transpose, lowest-set-lane select, and at-most-one-bit detection
    always_comb begin
        act_val_s   = '0;
        act_sel_s   = '0;
        single_s    = '0;
        mask_clr_s  = '0;
        mask_load_s = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            act_val_s[j]  = (state_r == RUN) && (|mask_r[j]);
            // m & (m-1) drops the lowest set bit, which is exactly the lane selected this beat
            mask_clr_s[j] = mask_r[j] & (mask_r[j] - ONE_V);
            single_s[j]   = (mask_clr_s[j] == '0);
            for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
                if (mask_r[j][i] && (state_r == RUN)) begin
                    act_sel_s[j] = MUX_SEL_WIDTH'(i);
                end else begin
                    act_sel_s[j] = act_sel_s[j];
                end
            end
            for (int i = 0; i < VEC_LENGTH; i++) begin
                mask_load_s[j][i] = bus.w_in[i][j];
            end
        end
    end

    assign out_valid_s = (state_r == RUN);
    assign last_s      = out_valid_s && (&single_s);
    assign beat_done_s = out_valid_s && bus.out_ready;
    assign w_ready_s   = (state_r == IDLE) || (beat_done_s && last_s);
    assign accept_s    = bus.w_valid && w_ready_s;

    // Next-state and next-mask selection; a load on the last handshake keeps RUN with no bubble
    always_comb begin
        state_nxt_s = state_r;
        mask_nxt_s  = mask_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                    mask_nxt_s  = mask_load_s;
                end else begin
                    state_nxt_s = IDLE;
                    mask_nxt_s  = mask_r;
                end
            end
            RUN: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                    mask_nxt_s  = mask_load_s;
                end else if (beat_done_s) begin
                    state_nxt_s = last_s ? IDLE : RUN;
                    mask_nxt_s  = mask_clr_s;
                end else begin
                    state_nxt_s = RUN;
                    mask_nxt_s  = mask_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                mask_nxt_s  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bit-plane mask register; reset discards any in-flight vector
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= '0;
        end else begin
            mask_r <= mask_nxt_s;
        end
    end

    assign bus.w_ready   = w_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.act_sel   = act_sel_s;
    assign bus.act_val   = act_val_s;
    assign bus.last      = last_s;
endmodule
